// File: rtl/incenter_tx_driver_if.sv
// Bus bundle between the incenter transmit driver and its user / engine.
//   TRI_*  : triangle request handshake and vertex coordinates (user -> driver)
//   TX_*   : serial word stream to the engine input (driver -> engine)
//   RX_*   : engine result stream (engine -> driver)
//   RES_*  : captured incenter result (driver -> user)
// Modport slave is the driver side; modport master is the user/engine side.
interface incenter_tx_driver_if #(
  parameter int COORD_W = 8
);
  logic               TRI_VALID;
  logic               TRI_READY;
  logic [COORD_W-1:0] TRI_X1;
  logic [COORD_W-1:0] TRI_X2;
  logic [COORD_W-1:0] TRI_X3;
  logic [COORD_W-1:0] TRI_Y1;
  logic [COORD_W-1:0] TRI_Y2;
  logic [COORD_W-1:0] TRI_Y3;
  logic [16:0]        TX_DATA;
  logic               TX_VALID;
  logic [15:0]        RX_DATA;
  logic               RX_VALID;
  logic               RES_VALID;
  logic [15:0]        RES_X;
  logic [15:0]        RES_Y;
  logic               RES_DEGEN;

  modport slave (
    input  TRI_VALID, TRI_X1, TRI_X2, TRI_X3, TRI_Y1, TRI_Y2, TRI_Y3,
    input  RX_DATA, RX_VALID,
    output TRI_READY, TX_DATA, TX_VALID,
    output RES_VALID, RES_X, RES_Y, RES_DEGEN
  );

  modport master (
    output TRI_VALID, TRI_X1, TRI_X2, TRI_X3, TRI_Y1, TRI_Y2, TRI_Y3,
    output RX_DATA, RX_VALID,
    input  TRI_READY, TX_DATA, TX_VALID,
    input  RES_VALID, RES_X, RES_Y, RES_DEGEN
  );
endinterface

// File: rtl/incenter_tx_driver.sv
// Transmit-side partner of the incenter engine.
// Accepts a triangle (three vertices), computes the three side lengths with a
// restoring integer square root (one root bit per cycle, sides in sequence),
// then serialises X1,Y1,X2,Y2,X3,Y3,a,b,c onto the engine input stream aligned
// to the engine's 9-slot frame. The X/Y words the engine returns after our
// frame are captured and presented as one result pulse. A triangle whose sides
// are all zero bypasses the engine and reports vertex 1 as the incenter.
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset, shared with the engine
//   bus   : incenter_tx_driver_if.slave (request, TX stream, RX stream, result)
module incenter_tx_driver #(
  parameter int COORD_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  incenter_tx_driver_if.slave  bus
);

  localparam int RW    = COORD_W + 1;   // root width
  localparam int REM_W = COORD_W + 3;   // remainder / trial width

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SQRT     = 3'd1;
  localparam logic [2:0] S_SYNC     = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_WAIT_RES = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]         state;
  logic [3:0]         slot;
  logic [3:0]         nxt_slot;

  logic [COORD_W-1:0] x1, y1, x2, y2, x3, y3;
  logic [RW-1:0]      side_a, side_b, side_c;

  logic [1:0]         side_idx;
  logic [4:0]         bit_idx;
  logic [REM_W-1:0]   rem;
  logic [RW-1:0]      root;

  logic [15:0]        rx_x;
  logic               got_x;

  logic [16:0]        tx_data;
  logic               tx_valid;
  logic               res_valid;
  logic [15:0]        res_x;
  logic [15:0]        res_y;
  logic               res_degen;

  // Square-root datapath
  logic [COORD_W-1:0]   pa_x, pa_y, pb_x, pb_y, dx, dy;
  logic [2*COORD_W-1:0] dx2, dy2;
  logic [2*COORD_W:0]   dsq;
  logic [2*COORD_W+1:0] d_pad;
  logic [1:0]           pair;
  logic [REM_W-1:0]     rem_sh, trial, rem_nx;
  logic [RW-1:0]        root_nx;
  logic                 degen;
  logic [16:0]          tx_word;

  assign nxt_slot = (slot == 4'd9) ? 4'd1 : slot + 4'd1;

  // Endpoints of the side currently being rooted: 0=a(P2P3), 1=b(P1P3), 2=c(P1P2)
  always_comb begin
    pa_x = x1;
    pa_y = y1;
    pb_x = x2;
    pb_y = y2;
    case (side_idx)
      2'd0: begin
        pa_x = x2; pa_y = y2; pb_x = x3; pb_y = y3;
      end
      2'd1: begin
        pa_x = x1; pa_y = y1; pb_x = x3; pb_y = y3;
      end
      default: begin
        pa_x = x1; pa_y = y1; pb_x = x2; pb_y = y2;
      end
    endcase
  end

  always_comb begin
    dx    = (pa_x > pb_x) ? (pa_x - pb_x) : (pb_x - pa_x);
    dy    = (pa_y > pb_y) ? (pa_y - pb_y) : (pb_y - pa_y);
    dx2   = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
    dy2   = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
    dsq   = {1'b0, dx2} + {1'b0, dy2};
    // Pad to an even width so the radicand splits into RW bit-pairs.
    d_pad = {1'b0, dsq};
    pair  = 2'(d_pad >> {bit_idx, 1'b0});
    // Restoring step: bring down the next pair, try subtracting 4*root+1.
    rem_sh = REM_W'({rem, pair});
    trial  = {root, 2'b01};
    if (rem_sh >= trial) begin
      rem_nx  = rem_sh - trial;
      root_nx = {root[RW-2:0], 1'b1};
    end else begin
      rem_nx  = rem_sh;
      root_nx = {root[RW-2:0], 1'b0};
    end
  end

  // All sides are unsigned, so a+b+c==0 exactly when every side is zero.
  assign degen = (side_a == '0) && (side_b == '0) && (side_c == '0);

  // Word that belongs in the upcoming slot.
  always_comb begin
    tx_word = '0;
    case (nxt_slot)
      4'd1:    tx_word = 17'(x1);
      4'd2:    tx_word = 17'(y1);
      4'd3:    tx_word = 17'(x2);
      4'd4:    tx_word = 17'(y2);
      4'd5:    tx_word = 17'(x3);
      4'd6:    tx_word = 17'(y3);
      4'd7:    tx_word = 17'(side_a);
      4'd8:    tx_word = 17'(side_b);
      4'd9:    tx_word = 17'(side_c);
      default: tx_word = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      slot      <= 4'd1;
      x1        <= '0;
      y1        <= '0;
      x2        <= '0;
      y2        <= '0;
      x3        <= '0;
      y3        <= '0;
      side_a    <= '0;
      side_b    <= '0;
      side_c    <= '0;
      side_idx  <= '0;
      bit_idx   <= '0;
      rem       <= '0;
      root      <= '0;
      rx_x      <= '0;
      got_x     <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      res_valid <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      res_degen <= 1'b0;
    end else begin
      slot      <= nxt_slot;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.TRI_VALID) begin
            x1       <= bus.TRI_X1;
            y1       <= bus.TRI_Y1;
            x2       <= bus.TRI_X2;
            y2       <= bus.TRI_Y2;
            x3       <= bus.TRI_X3;
            y3       <= bus.TRI_Y3;
            side_idx <= '0;
            bit_idx  <= 5'(COORD_W);
            rem      <= '0;
            root     <= '0;
            state    <= S_SQRT;
          end
        end

        S_SQRT: begin
          if (bit_idx == '0) begin
            case (side_idx)
              2'd0:    side_a <= root_nx;
              2'd1:    side_b <= root_nx;
              default: side_c <= root_nx;
            endcase
            rem     <= '0;
            root    <= '0;
            bit_idx <= 5'(COORD_W);
            if (side_idx == 2'd2) begin
              state <= S_SYNC;
            end else begin
              side_idx <= side_idx + 2'd1;
            end
          end else begin
            rem     <= rem_nx;
            root    <= root_nx;
            bit_idx <= bit_idx - 5'd1;
          end
        end

        S_SYNC: begin
          if (degen) begin
            res_x     <= 16'(x1);
            res_y     <= 16'(y1);
            res_degen <= 1'b1;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end else if (slot == 4'd9) begin
            // Registered output: word 1 appears in the cycle whose slot is 1.
            tx_valid <= 1'b1;
            tx_data  <= tx_word;
            state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (slot == 4'd9) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            got_x    <= 1'b0;
            state    <= S_WAIT_RES;
          end else begin
            tx_data <= tx_word;
          end
        end

        S_WAIT_RES: begin
          if (bus.RX_VALID) begin
            if (!got_x) begin
              rx_x  <= bus.RX_DATA;
              got_x <= 1'b1;
            end else begin
              // X is staged in rx_x so RES_X/RES_Y change together.
              res_x     <= rx_x;
              res_y     <= bus.RX_DATA;
              res_degen <= 1'b0;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.TRI_READY = (state == S_IDLE);
  assign bus.TX_DATA   = tx_data;
  assign bus.TX_VALID  = tx_valid;
  assign bus.RES_VALID = res_valid;
  assign bus.RES_X     = res_x;
  assign bus.RES_Y     = res_y;
  assign bus.RES_DEGEN = res_degen;

endmodule

// File: tb/tb_incenter_tx_driver.sv
// Testbench for incenter_tx_driver: directed triangles with hand-computed TX
// words and results. Expected TX words and results are queued when a request
// is issued; independent monitors pop and compare them. A small engine model
// tracks the frame slot, answers each completed frame in the next frame, and
// also emits a stale result pulse in the middle of every frame it receives.
module tb_incenter_tx_driver;

  localparam int W = 8;

  typedef struct {
    int word;
    int slot;
  } tx_exp_t;

  typedef struct {
    int x;
    int y;
  } rsp_t;

  typedef struct {
    int x;
    int y;
    int degen;
    bit lat;
  } res_exp_t;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  incenter_tx_driver_if #(.COORD_W(W)) bus();

  incenter_tx_driver #(.COORD_W(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  tx_exp_t  tx_q[$];
  rsp_t     rsp_q[$];
  res_exp_t res_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tb_slot = 1;
  int last_acc = 0;
  int first_tx_cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET) tb_slot <= 1;
    else       tb_slot <= (tb_slot == 9) ? 1 : tb_slot + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // TX / result monitor
  initial begin
    tx_exp_t  t;
    res_exp_t r;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (bus.TX_VALID) begin
          if (tx_q.size() == 0) begin
            check("tx_unexpected", int'(bus.TX_VALID), 0);
          end else begin
            t = tx_q.pop_front();
            check("tx_word", int'(bus.TX_DATA), t.word);
            check("tx_slot", tb_slot, t.slot);
            if (t.slot == 1) first_tx_cyc = cyc;
          end
        end else begin
          check("tx_idle_data", int'(bus.TX_DATA), 0);
        end
        if (bus.RES_VALID) begin
          if (res_q.size() == 0) begin
            check("res_unexpected", int'(bus.RES_VALID), 0);
          end else begin
            r = res_q.pop_front();
            check("res_x", int'(bus.RES_X), r.x);
            check("res_y", int'(bus.RES_Y), r.y);
            check("res_degen", int'(bus.RES_DEGEN), r.degen);
            if (r.lat) check("res_latency", cyc - last_acc, 3 * (W + 1) + 1);
          end
        end
      end
    end
  end

  // Engine model
  initial begin
    rsp_t r;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = '0;
    forever begin
      @(negedge CLK);
      if (mon_en && bus.TX_VALID && tb_slot == 4) begin
        bus.RX_DATA  = 16'hBEEF;
        bus.RX_VALID = 1'b1;
        @(negedge CLK);
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = '0;
      end else if (mon_en && bus.TX_VALID && tb_slot == 9) begin
        if (rsp_q.size() == 0) begin
          check("engine_rsp_missing", int'(rsp_q.size()), 1);
        end else begin
          r = rsp_q.pop_front();
          @(negedge CLK);
          for (int k = 0; k < 20 && tb_slot != 3; k++) @(negedge CLK);
          bus.RX_DATA  = 16'(r.x);
          bus.RX_VALID = 1'b1;
          @(negedge CLK);
          bus.RX_VALID = 1'b0;
          for (int k = 0; k < 20 && tb_slot != 5; k++) @(negedge CLK);
          bus.RX_DATA  = 16'(r.y);
          bus.RX_VALID = 1'b1;
          @(negedge CLK);
          bus.RX_VALID = 1'b0;
          bus.RX_DATA  = '0;
        end
      end
    end
  end

  // Queue expectations; w holds X1,Y1,X2,Y2,X3,Y3,a,b,c.
  task automatic expect_tri(input int w[9], input int rx, input int ry, input bit degen);
    if (!degen) begin
      for (int i = 0; i < 9; i++) tx_q.push_back('{w[i], i + 1});
      rsp_q.push_back('{rx, ry});
      res_q.push_back('{rx, ry, 0, 1'b0});
    end else begin
      res_q.push_back('{rx, ry, 1, 1'b1});
    end
  endtask

  // Issue a request (optionally starting when the frame slot equals want).
  task automatic send_tri(input int w[9], input int want);
    bit ok;
    ok = 1'b0;
    @(negedge CLK);
    if (want > 0) for (int k = 0; k < 20 && tb_slot != want; k++) @(negedge CLK);
    bus.TRI_X1 = W'(w[0]);
    bus.TRI_Y1 = W'(w[1]);
    bus.TRI_X2 = W'(w[2]);
    bus.TRI_Y2 = W'(w[3]);
    bus.TRI_X3 = W'(w[4]);
    bus.TRI_Y3 = W'(w[5]);
    bus.TRI_VALID = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (bus.TRI_READY) begin
        @(posedge CLK);
        #1;
        ok = 1'b1;
        last_acc = cyc;
      end else begin
        @(negedge CLK);
      end
    end
    check("accept", int'(ok), 1);
    @(negedge CLK);
    bus.TRI_VALID = 1'b0;
  endtask

  task automatic wait_results();
    for (int i = 0; i < 3000 && res_q.size() != 0; i++) @(negedge CLK);
    check("result_pending", int'(res_q.size()), 0);
  endtask

  int w1[9]  = '{0, 0, 4, 0, 0, 3, 5, 3, 4};
  int w2[9]  = '{0, 0, 1, 1, 2, 0, 1, 2, 1};
  int w3[9]  = '{7, 9, 7, 9, 7, 9, 0, 0, 0};
  int w4[9]  = '{10, 20, 40, 60, 10, 60, 30, 40, 50};
  int w5[9]  = '{255, 255, 0, 0, 255, 0, 255, 255, 360};

  initial begin
    bit found;
    RESET         = 1'b1;
    bus.TRI_VALID = 1'b0;
    bus.TRI_X1 = '0; bus.TRI_Y1 = '0;
    bus.TRI_X2 = '0; bus.TRI_Y2 = '0;
    bus.TRI_X3 = '0; bus.TRI_Y3 = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_tri_ready", int'(bus.TRI_READY), 1);
    check("rst_tx_valid", int'(bus.TX_VALID), 0);
    check("rst_tx_data", int'(bus.TX_DATA), 0);
    check("rst_res_valid", int'(bus.RES_VALID), 0);
    check("rst_res_x", int'(bus.RES_X), 0);
    check("rst_res_y", int'(bus.RES_Y), 0);
    check("rst_res_degen", int'(bus.RES_DEGEN), 0);
    RESET  = 1'b0;
    mon_en = 1'b1;

    // 1: 3-4-5 triangle
    expect_tri(w1, 1, 1, 1'b0);
    send_tri(w1, 0);
    wait_results();

    // 2: floor of sqrt(2)
    expect_tri(w2, 1, 0, 1'b0);
    send_tri(w2, 0);
    wait_results();

    // 3: degenerate bypass, accept-to-result latency checked by the monitor
    expect_tri(w3, 7, 9, 1'b1);
    send_tri(w3, 0);
    wait_results();
    repeat (5) @(negedge CLK);
    check("hold_res_x", int'(bus.RES_X), 7);
    check("hold_res_y", int'(bus.RES_Y), 9);
    check("hold_res_degen", int'(bus.RES_DEGEN), 1);

    // 4: SQRT ends in slot 3; busy request ignored
    expect_tri(w4, 20, 50, 1'b0);
    send_tri(w4, 3);
    bus.TRI_X1 = 8'd1; bus.TRI_Y1 = 8'd2;
    bus.TRI_X2 = 8'd3; bus.TRI_Y2 = 8'd4;
    bus.TRI_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("busy_ready", int'(bus.TRI_READY), 0);
      @(negedge CLK);
    end
    bus.TRI_VALID = 1'b0;
    wait_results();
    check("first_tx_latency", first_tx_cyc - last_acc, 3 * (W + 1) + 6);

    // Full-scale coordinates: longest side needs all COORD_W+1 root bits
    expect_tri(w5, 16'hFFFF, 16'h8000, 1'b0);
    send_tri(w5, 0);
    wait_results();

    // 5: reset during SEND slot 5
    expect_tri(w1, 1, 1, 1'b0);
    send_tri(w1, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.TX_VALID && tb_slot == 5) found = 1'b1;
      else @(negedge CLK);
    end
    check("reach_slot5", int'(found), 1);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_tx_valid", int'(bus.TX_VALID), 0);
    check("mid_rst_tri_ready", int'(bus.TRI_READY), 1);
    check("mid_rst_res_valid", int'(bus.RES_VALID), 0);
    RESET = 1'b0;
    tx_q.delete();
    rsp_q.delete();
    res_q.delete();
    expect_tri(w1, 1, 1, 1'b0);
    send_tri(w1, 0);
    wait_results();

    // 6: back-to-back requests
    expect_tri(w1, 1, 1, 1'b0);
    send_tri(w1, 0);
    expect_tri(w2, 1, 0, 1'b0);
    send_tri(w2, 0);
    wait_results();

    repeat (40) @(negedge CLK);
    check("drain", int'(tx_q.size() + rsp_q.size() + res_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
